// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and its ALU decoder.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
    S_LUI, S_AUIPC, S_FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BR:            return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aluDecoder.sv
// ALU operation and data-memory access-size decode from funct fields and ALUOp.
module aluDecoder
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [3:0] ALUControl,
  output logic [2:0] DATAMEMControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Loads and stores carry their byte/half/word and sign variant in funct3.
  assign DATAMEMControl = funct3;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// with memory wait states and an optional per-access timeout.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [2:0] DATAMEMControl,
  output logic       illegal,
  output logic       instr_retired
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic [TO_W-1:0] wait_cnt;
  logic [1:0]      alu_op;
  logic            mem_access;
  logic            timeout;

  assign mem_access = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout    = (MEM_TIMEOUT != 0) && mem_access && !mem_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || mem_ready || !mem_access)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BR:             state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_FAULT;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR:     state_next = S_JALR2;
      S_JALR2:    state_next = S_ALUWB;
      S_LUI:      state_next = S_FETCH;
      S_AUIPC:    state_next = S_ALUWB;
      S_FAULT:    state_next = S_FAULT;
      default:    state_next = S_FAULT;
    endcase
    if (timeout) state_next = S_FAULT;
  end

  // Reset overrides every enable so an access in flight is abandoned cleanly.
  always_comb begin
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    illegal       = 1'b0;
    ImmSrc        = imm_src_of(op);
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
        end
      end
      S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      S_MEMADR:   begin ALUSrcA = SRCA_RD1;   ALUSrcB = SRCB_IMM; end
      S_MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = RES_MEMDATA; RegWrite = 1'b1; end
      S_MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = SRCA_RD1; ALUSrcB = SRCB_RD2; alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin ALUSrcA = SRCA_RD1; ALUSrcB = SRCB_IMM; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin ResultSrc = RES_ALUOUT; RegWrite = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_SUB;
        PCWrite = zero ^ funct3[0];
      end
      S_JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; PCWrite = 1'b1; end
      S_JALR:     begin ALUSrcA = SRCA_RD1;   ALUSrcB = SRCB_IMM; end
      S_JALR2:    begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; PCWrite = 1'b1; end
      S_LUI:      begin ResultSrc = RES_IMMEXT; RegWrite = 1'b1; end
      S_AUIPC:    begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      S_FAULT:    illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
    instr_retired = (state != S_FETCH) && (state_next == S_FETCH);
    if (rst) begin
      mem_req       = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      illegal       = 1'b0;
      instr_retired = 1'b0;
    end
  end

  aluDecoder u_alu_decoder (
    .funct3         (funct3),
    .funct7_5       (funct7_5),
    .op5            (op[5]),
    .alu_op         (alu_op),
    .ALUControl     (ALUControl),
    .DATAMEMControl (DATAMEMControl)
  );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequences the shared-memory multicycle RV32I datapath: one instruction over 3-5 states, with memory wait states.
- Drives the PC, IR, register-file and memory enables, plus the mux selects and ALU control for each cycle.
- Replaces the combinational control unit when the core is built in multicycle mode.

Parameters:
MEM_TIMEOUT, 0, maximum wait cycles on one memory access before a bus error; 0 disables the timeout.
TO_W, 8, width of the wait counter; MEM_TIMEOUT < 2**TO_W.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
op  in  7  opcode from IR
funct3  in  3  from IR
funct7_5  in  1  IR bit 30
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  load IR
PCWrite  out  1  load PC from Result
MemWrite  out  1  store strobe
RegWrite  out  1  register-file write
ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult, 11=ImmExt
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=const 4
ALUControl  out  4  from aluDecoder
ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
DATAMEMControl  out  3  from aluDecoder
illegal  out  1  sticky fault: bad opcode or memory timeout
instr_retired  out  1  one-cycle pulse per completed instruction

Behaviour:
- Outputs are a combinational decode of state, plus mem_ready, zero and funct3 where stated. Unlisted enables are 0; unlisted selects are 00.
- ALUOp is 00 (add) unless stated.
- ImmSrc is decoded from op in every state.
- Reset: while rst=1 all enables, mem_req, illegal and instr_retired are 0. State becomes FETCH and the wait counter clears at the edge. Reset mid-access aborts the access; no partial writes are issued after that edge.

States and transitions:
- FETCH: mem_req=1, AdrSrc=0. Stays in FETCH while mem_ready=0.
  - On mem_ready=1 in the same cycle: IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01 (branch target into ALUOut). Dispatch on op:
  - 0000011, 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other op -> FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held through all wait cycles. On mem_ready, next FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. taken = zero XOR funct3[0]; PCWrite=taken. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Next ALUWB (rd gets OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01. Next JALR2.
- JALR2: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Next ALUWB.
- LUI: ResultSrc=11, RegWrite=1. Next FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01. Next ALUWB.
- FAULT: illegal=1, all enables 0. Exits only on rst.

Retirement:
- instr_retired=1 in any cycle whose next state is FETCH and whose current state is not FETCH.

Memory timeout:
- The wait counter increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or a state change.
- If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, next state is FAULT. MemWrite drops at that edge.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Shared package holds:
  - state_t enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings
  - ALUOp encodings
- Instantiate the existing aluDecoder unchanged: funct3, funct7_5, op[5] and the state-selected ALUOp in; ALUControl and DATAMEMControl out.
- One state register plus the wait counter. No other sub-module.

Test Plan:
- add x3,x1,x2 with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite in cycle 4; instr_retired pulse in cycle 4; PCWrite only in cycle 1.
- lw with mem_ready low 3 cycles in MEMREAD -> 8 cycles total; RegWrite=1 with ResultSrc=01 exactly once; mem_req stays high through the wait.
- beq: zero=1 -> PCWrite=1 in BRANCH; zero=0 -> PCWrite=0. bne (funct3=001) with zero=0 -> PCWrite=1.
- jalr -> JALR then JALR2 with PCWrite=1, then ALUWB with RegWrite=1; 5 cycles total.
- op=0000000 -> FAULT, illegal=1; 100 cycles of stimulus produce no enables; rst=1 for one cycle -> FETCH, illegal=0.
- MEM_TIMEOUT=4, sw with mem_ready stuck at 0 -> MemWrite high 4 cycles, then FAULT. Separately, rst mid-MEMWRITE -> MemWrite=0 in the reset cycle, then FETCH.
